// File: rtl/mem_pkg.sv
// Shared types for the MEM pipeline stage: access sizes, handshake FSM states,
// the MEM/WB control bundle and the alignment rule.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        misalign;
        logic [31:0] ir;
    } mem_wb_ctrl_t;

    // Low three address bits decide alignment; a dword is only legal on a 64-bit datapath.
    function automatic logic addr_misaligned(input mem_size_e size, input logic [2:0] low,
                                             input logic dword_ok);
        logic bad;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = low[0];
            MEM_W:   bad = |low[1:0];
            default: bad = ~dword_ok | (|low);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load lane extraction: shift the addressed bytes of a memory word down to bit 0,
// then sign- or zero-extend to the datapath width.
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              rdata,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  mem_size_e                    size,
    input  logic                         is_unsigned,
    output logic [XLEN-1:0]              data
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        data = shifted;
        case (size)
            MEM_B:   data = is_unsigned ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
            MEM_H:   data = is_unsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
            MEM_W:   data = is_unsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: sized/aligned data-memory access over a req/gnt/rvalid
// handshake, store-data forwarding, pipeline stall and the MEM/WB register.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ex_valid,
    input  logic [31:0]             ex_ir,
    input  logic [XLEN-1:0]         ex_alu_out,
    input  logic [XLEN-1:0]         ex_b,
    input  logic                    ex_load,
    input  logic                    ex_store,
    input  logic [1:0]              ex_size,
    input  logic                    ex_unsigned,
    input  logic                    ex_reg_write,
    input  logic [NUM_FWD-1:0]      fwd_en,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [XLEN-1:0]         mem_addr,
    output logic [XLEN/8-1:0]       mem_be,
    output logic [XLEN-1:0]         mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [XLEN-1:0]         mem_rdata,
    output logic                    stall,
    output logic                    wb_valid,
    output logic                    wb_reg_write,
    output logic                    wb_misalign,
    output logic [31:0]             wb_ir,
    output logic [XLEN-1:0]         wb_alu_out,
    output logic [XLEN-1:0]         wb_load_data
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    mem_state_e      state, state_n;
    mem_size_e       size;
    logic [OFFW-1:0] offset;
    logic            mem_op, misaligned;
    logic [XLEN-1:0] store_data, load_data;
    mem_wb_ctrl_t    wb_ctrl;
    logic [XLEN-1:0] wb_alu_q, wb_load_q;

    assign size       = mem_size_e'(ex_size);
    assign offset     = ex_alu_out[OFFW-1:0];
    assign mem_op     = ex_valid & (ex_load | ex_store);
    assign misaligned = mem_op & addr_misaligned(size, ex_alu_out[2:0], XLEN == 64);

    // Reset gates the handshake outputs so nothing escapes while the pipe is being cleared.
    assign mem_req  = ~reset & (state == IDLE) & mem_op & ~misaligned;
    assign mem_we   = ex_store;
    assign mem_addr = {ex_alu_out[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign stall    = ~reset & (((state == IDLE) & mem_req & (~mem_gnt | ex_load)) |
                                ((state == RESP) & ~mem_rvalid));

    always_comb begin
        store_data = ex_b;
        // Walk from the highest index down so the lowest enabled source is written last and wins.
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_en[i]) store_data = fwd_data[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        mem_be    = '0;
        mem_wdata = '0;
        case (size)
            MEM_B: begin
                mem_be    = NB'(1) << offset;
                mem_wdata = {NB{store_data[7:0]}};
            end
            MEM_H: begin
                mem_be    = NB'(3) << offset;
                mem_wdata = {(NB/2){store_data[15:0]}};
            end
            MEM_W: begin
                mem_be    = NB'(15) << offset;
                mem_wdata = {(NB/4){store_data[31:0]}};
            end
            default: begin
                mem_be    = '1;
                mem_wdata = store_data;
            end
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata       (mem_rdata),
        .offset      (offset),
        .size        (size),
        .is_unsigned (ex_unsigned),
        .data        (load_data)
    );

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (mem_req && mem_gnt && ex_load) state_n = RESP;
            RESP: if (mem_rvalid) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ctrl   <= '0;
            wb_alu_q  <= '0;
            wb_load_q <= '0;
        end else if (stall) begin
            wb_ctrl.valid <= 1'b0;
        end else begin
            wb_ctrl   <= '{valid:     ex_valid,
                           reg_write: ex_reg_write & ~misaligned,
                           misalign:  misaligned,
                           ir:        ex_ir};
            wb_alu_q  <= ex_alu_out;
            wb_load_q <= (ex_valid & ex_load & ~misaligned) ? load_data : '0;
        end
    end

    assign wb_valid     = wb_ctrl.valid;
    assign wb_reg_write = wb_ctrl.reg_write;
    assign wb_misalign  = wb_ctrl.misalign;
    assign wb_ir        = wb_ctrl.ir;
    assign wb_alu_out   = wb_alu_q;
    assign wb_load_data = wb_load_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (XLEN=32, NUM_FWD=2): a vector table
// with a handshaking memory model and a WB scoreboard, plus reset corner cases.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_load, ex_store, ex_unsigned, ex_reg_write;
    logic [31:0] ex_ir, ex_alu_out, ex_b;
    logic [1:0]  ex_size;
    logic [1:0]  fwd_en;
    logic [63:0] fwd_data;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall, wb_valid, wb_reg_write, wb_misalign;
    logic [31:0] wb_ir, wb_alu_out, wb_load_data;

    int total = 0;
    int bad   = 0;

    mem_access_stage #(.XLEN(32), .NUM_FWD(2)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ir(ex_ir), .ex_alu_out(ex_alu_out), .ex_b(ex_b),
        .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_reg_write(ex_reg_write),
        .fwd_en(fwd_en), .fwd_data(fwd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall(stall),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_misalign(wb_misalign),
        .wb_ir(wb_ir), .wb_alu_out(wb_alu_out), .wb_load_data(wb_load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld, st, rw;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr, b;
        logic [1:0]  fen;
        logic [31:0] f0, f1, rdata;
        int          gw, rvw;
        logic        ereq;
        logic [31:0] eaddr;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic        emis;
        logic [31:0] eld;
    } vec_t;

    typedef struct {
        logic        valid, rw, mis;
        logic [31:0] ir, alu, ld;
    } wb_exp_t;

    wb_exp_t exp_q[$];
    vec_t    vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid = 0; ex_load = 0; ex_store = 0; ex_unsigned = 0; ex_reg_write = 0;
        ex_ir = '0; ex_alu_out = '0; ex_b = '0; ex_size = '0;
        fwd_en = '0; fwd_data = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the edge that retires the op.
    task automatic run_op(input vec_t v, input int idx);
        int      cyc = 0, stalls = 0, reqs = 0, gnt_cycle = -1, exp_stalls;
        bit      granted = 0, done = 0;
        wb_exp_t e, got;
        ex_valid = 1; ex_load = v.ld; ex_store = v.st; ex_reg_write = v.rw;
        ex_size = v.size; ex_unsigned = v.uns; ex_alu_out = v.addr; ex_b = v.b;
        ex_ir = 32'h1000_0000 + idx;
        fwd_en = v.fen; fwd_data = {v.f1, v.f0};
        e = '{valid: 1'b1, rw: v.rw & ~v.emis, mis: v.emis, ir: 32'h1000_0000 + idx,
              alu: v.addr, ld: v.eld};
        exp_q.push_back(e);
        exp_stalls = v.ereq ? v.gw + (v.ld ? 1 + v.rvw : 0) : 0;
        while (!done && cyc < 60) begin
            mem_gnt    = !granted && cyc >= v.gw;
            mem_rvalid = (granted && v.ld && cyc >= gnt_cycle + 1 + v.rvw) || !v.ld;
            mem_rdata  = (granted && v.ld) ? v.rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            if (cyc == 0) begin
                check($sformatf("v%0d mem_req", idx), mem_req, v.ereq);
                if (v.ereq) begin
                    check($sformatf("v%0d mem_we", idx), mem_we, v.st);
                    check($sformatf("v%0d mem_addr", idx), mem_addr, v.eaddr);
                    check($sformatf("v%0d mem_be", idx), mem_be, v.ebe);
                    if (v.st) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.ewd);
                end
            end else if (stall) begin
                check($sformatf("v%0d wb_valid in stall", idx), wb_valid, 1'b0);
            end
            if (mem_req) reqs++;
            if (stall) stalls++; else done = 1;
            if (mem_req && mem_gnt && !granted) begin granted = 1; gnt_cycle = cyc; end
            @(posedge clk); #1;
            cyc++;
        end
        mem_gnt = 0; mem_rvalid = 0;
        if (!done) check($sformatf("v%0d timeout", idx), 1, 0);
        check($sformatf("v%0d stall cycles", idx), stalls, exp_stalls);
        check($sformatf("v%0d req cycles", idx), reqs, v.ereq ? v.gw + 1 : 0);
        got = exp_q.pop_front();
        check($sformatf("v%0d wb_valid", idx), wb_valid, got.valid);
        check($sformatf("v%0d wb_reg_write", idx), wb_reg_write, got.rw);
        check($sformatf("v%0d wb_misalign", idx), wb_misalign, got.mis);
        check($sformatf("v%0d wb_ir", idx), wb_ir, got.ir);
        check($sformatf("v%0d wb_alu_out", idx), wb_alu_out, got.alu);
        check($sformatf("v%0d wb_load_data", idx), wb_load_data, got.ld);
    endtask

    initial begin
        //         ld st rw sz uns addr          b              fen    f0             f1             rdata          gw rvw req eaddr     be    wdata          mis eld
        vecs[0]  = '{0, 0, 1, 0, 0, 32'h1234,     32'h0,         2'b00, 32'h0,         32'h0,         32'h0,         0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 32'h0};
        vecs[1]  = '{0, 1, 0, 0, 0, 32'h103,      32'hAB,        2'b11, 32'h55,        32'h66,        32'h0,         0, 0, 1, 32'h100, 4'h8, 32'h55555555,  0, 32'h0};
        vecs[2]  = '{0, 1, 0, 0, 0, 32'h101,      32'h123456AB,  2'b00, 32'h55,        32'h66,        32'h0,         0, 0, 1, 32'h100, 4'h2, 32'hABABABAB,  0, 32'h0};
        vecs[3]  = '{0, 1, 0, 1, 0, 32'h102,      32'h0,         2'b10, 32'h99,        32'h1234BEEF,  32'h0,         0, 0, 1, 32'h100, 4'hC, 32'hBEEFBEEF,  0, 32'h0};
        vecs[4]  = '{0, 1, 0, 2, 0, 32'h200,      32'hCAFEF00D,  2'b00, 32'h0,         32'h0,         32'h0,         2, 0, 1, 32'h200, 4'hF, 32'hCAFEF00D,  0, 32'h0};
        vecs[5]  = '{1, 0, 1, 1, 0, 32'h102,      32'h0,         2'b00, 32'h0,         32'h0,         32'h80010000,  0, 3, 1, 32'h100, 4'hC, 32'h0,         0, 32'hFFFF8001};
        vecs[6]  = '{1, 0, 1, 1, 1, 32'h102,      32'h0,         2'b00, 32'h0,         32'h0,         32'h80010000,  0, 3, 1, 32'h100, 4'hC, 32'h0,         0, 32'h00008001};
        vecs[7]  = '{1, 0, 1, 2, 0, 32'h101,      32'h0,         2'b00, 32'h0,         32'h0,         32'h0,         0, 0, 0, 32'h0,   4'h0, 32'h0,         1, 32'h0};
        vecs[8]  = '{1, 0, 1, 0, 0, 32'h103,      32'h0,         2'b00, 32'h0,         32'h0,         32'hF0123456,  1, 0, 1, 32'h100, 4'h8, 32'h0,         0, 32'hFFFFFFF0};
        vecs[9]  = '{1, 0, 1, 0, 1, 32'h100,      32'h0,         2'b00, 32'h0,         32'h0,         32'h000000F0,  0, 0, 1, 32'h100, 4'h1, 32'h0,         0, 32'h000000F0};
        vecs[10] = '{1, 0, 1, 2, 0, 32'h104,      32'h0,         2'b00, 32'h0,         32'h0,         32'h89ABCDEF,  0, 1, 1, 32'h104, 4'hF, 32'h0,         0, 32'h89ABCDEF};
        vecs[11] = '{0, 1, 0, 1, 0, 32'h101,      32'h1111,      2'b00, 32'h0,         32'h0,         32'h0,         0, 0, 0, 32'h0,   4'h0, 32'h0,         1, 32'h0};
        vecs[12] = '{1, 0, 1, 3, 0, 32'h108,      32'h0,         2'b00, 32'h0,         32'h0,         32'h0,         0, 0, 0, 32'h0,   4'h0, 32'h0,         1, 32'h0};
        vecs[13] = '{1, 0, 1, 1, 0, 32'h100,      32'h0,         2'b00, 32'h0,         32'h0,         32'h12348765,  2, 2, 1, 32'h100, 4'h3, 32'h0,         0, 32'hFFFF8765};
        vecs[14] = '{0, 1, 0, 2, 0, 32'h10C,      32'h11111111,  2'b01, 32'h0BADC0DE,  32'h22222222,  32'h0,         0, 0, 1, 32'h10C, 4'hF, 32'h0BADC0DE,  0, 32'h0};

        // Reset state: a pending store upstream must not raise mem_req or stall.
        drive_idle();
        reset = 1;
        ex_valid = 1; ex_store = 1; ex_size = 2'd2; ex_alu_out = 32'h40;
        #12;
        check("reset mem_req", mem_req, 1'b0);
        check("reset stall", stall, 1'b0);
        check("reset wb_valid", wb_valid, 1'b0);
        check("reset wb_ir", wb_ir, 32'h0);
        check("reset wb_alu_out", wb_alu_out, 32'h0);
        @(posedge clk); #1;
        drive_idle();
        reset = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) run_op(vecs[i], i);

        // Reset while a load response is outstanding; the late rvalid must be dropped.
        ex_valid = 1; ex_load = 1; ex_reg_write = 1; ex_size = 2'd2; ex_alu_out = 32'h300;
        ex_ir = 32'h2000_0000; mem_gnt = 1;
        @(negedge clk);
        check("rst-resp grant mem_req", mem_req, 1'b1);
        check("rst-resp grant stall", stall, 1'b1);
        @(posedge clk); #1;
        mem_gnt = 0;
        @(negedge clk);
        check("rst-resp waiting stall", stall, 1'b1);
        check("rst-resp waiting mem_req", mem_req, 1'b0);
        @(posedge clk); #1;
        drive_idle();
        reset = 1;
        #1;
        check("rst-resp stall in reset", stall, 1'b0);
        check("rst-resp wb_alu_out in reset", wb_alu_out, 32'h0);
        check("rst-resp wb_load_data in reset", wb_load_data, 32'h0);
        @(posedge clk); #1;
        reset = 0;
        mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        check("rst-resp late rvalid stall", stall, 1'b0);
        @(posedge clk); #1;
        mem_rvalid = 0;
        check("rst-resp wb_valid", wb_valid, 1'b0);
        check("rst-resp wb_reg_write", wb_reg_write, 1'b0);
        check("rst-resp wb_ir", wb_ir, 32'h0);
        check("rst-resp wb_alu_out", wb_alu_out, 32'h0);
        check("rst-resp wb_load_data", wb_load_data, 32'h0);
        run_op(vecs[0], 20);
        run_op(vecs[9], 21);

        check("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access (MEM) stage of the in-order 5-stage pipeline, between EX/MEM and WB. Generalises the original MEM stage with sized and aligned loads/stores, a req/gnt/rvalid data-memory handshake with pipeline stall, N-way prioritised store-data forwarding, and misalignment detection. Produces the registered MEM/WB bundle consumed by writeback.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- NUM_FWD, 2: number of store-data forwarding sources.
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX/MEM slot holds a real instruction.
- ex_ir  in  32  instruction word.
- ex_alu_out  in  XLEN  ALU result; byte address for loads/stores.
- ex_b  in  XLEN  rs2 value (store data).
- ex_load / ex_store  in  1 each  memory op type; never both set.
- ex_size  in  2  0 byte, 1 half, 2 word, 3 dword (XLEN=64 only).
- ex_unsigned  in  1  zero-extend load result.
- ex_reg_write  in  1  instruction writes rd.
- fwd_en  in  NUM_FWD  forwarding source i valid.
- fwd_data  in  NUM_FWD*XLEN  forwarding data, source i at slice i.
- mem_req  out  1  memory request.
- mem_we  out  1  1 store, 0 load.
- mem_addr  out  XLEN  address, aligned down to XLEN/8.
- mem_be  out  XLEN/8  byte enables.
- mem_wdata  out  XLEN  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  load data.
- stall  out  1  freeze IF..EX/MEM this cycle.
- wb_valid, wb_reg_write, wb_misalign  out  1 each  MEM/WB control.
- wb_ir  out  32; wb_alu_out, wb_load_data  out  XLEN.

## Operation
- FSM states IDLE, RESP. IDLE→RESP on load with mem_req&mem_gnt; RESP→IDLE on mem_rvalid.
- Misaligned: address not a multiple of access size, or size 3 with XLEN=32. No request; passes to WB with wb_misalign=1, wb_reg_write=0.
- IDLE: mem_req = ex_valid&(ex_load|ex_store)&~misaligned; mem_* combinational from ex_*. RESP: mem_req=0.
- Store data: lowest index i with fwd_en[i] wins, else ex_b. Byte replicated to every lane, half to every half-lane; mem_be marks only the addressed bytes.
- Load data: addressed bytes from mem_rdata, sign- or zero-extended per ex_unsigned; wb_load_data=0 for non-loads.
- stall = (IDLE & mem_req & ~mem_gnt) | (IDLE & mem_req & mem_gnt & ex_load) | (RESP & ~mem_rvalid).
- MEM/WB register: if stall, wb_valid<=0, other wb_* hold; else all wb_* <= current values, wb_valid<=ex_valid.
- mem_rvalid in IDLE and mem_gnt without mem_req are ignored.

## Timing
- Reset: state IDLE; all wb_* 0. mem_req 0 and stall 0 while reset asserted.
- Non-memory and misaligned ops: 1 cycle to WB, no stall.
- Store: completes at edge of grant cycle; stall only while waiting for mem_gnt.
- Load: grant cycle N stalls; earliest rvalid N+1; WB captures on rvalid edge. Minimum 2 cycles.
- ex_* held stable by upstream while stall=1.
- Reset during RESP: return to IDLE, outstanding response discarded.

## Structure
- Package mem_pkg: size enum (MEM_B, MEM_H, MEM_W, MEM_D), FSM state enum, MEM/WB struct.
- Sub-module load_align: lane extract plus sign/zero extension, purely combinational.

## Test plan
- ALU op, ex_alu_out=0x1234 -> next cycle wb_valid=1, wb_alu_out=0x1234, no stall, mem_req=0.
- SB addr 0x103, ex_b=0xAB, fwd_en=2'b11, fwd_data[0]=0x55 -> mem_be=0x8, mem_wdata=0x55555555, mem_addr=0x100.
- LH addr 0x102, gnt same cycle, rvalid 3 cycles later with rdata=0x8001_0000 -> stall held 4 cycles, wb_load_data=0xFFFF8001; LHU gives 0x00008001.
- LW addr 0x101 -> no mem_req, wb_misalign=1, wb_reg_write=0, no stall.
- SW with mem_gnt low for 2 cycles -> mem_req high 3 cycles, wb_valid=0 for 2 cycles then 1.
- Assert reset in RESP, then rvalid after release -> state IDLE, rvalid ignored, wb_* all 0.
